// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
// Front-end controller for the 3x3 convolution datapath.
// It loads an 8x8 binary image, one row byte per beat, into an internal bit
// buffer. It then walks every valid output position (6x6), every filter and
// every tap, driving the MAC with the matching pixel and weight index. Each
// finished position is handed downstream through a valid/ready handshake.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   ena                  global enable; low freezes all state
//   abort                synchronous abort back to IDLE (image kept)
//   load_valid/ready     row-load handshake, load_data bit b = column b
//   tap_pixel            image pixel under the current tap
//   w_addr, filt_idx     weight index (filt*N_TAPS + tap) and current filter
//   mac_en, acc_clr      accumulate strobe; acc_clr marks the first tap of a filter
//   res_valid/ready      result handshake for position pos_idx
//   pos_idx              output position 0..35 (x = pos%6, y = pos/6)
//   busy, frame_done     not-IDLE flag, one-cycle end-of-frame pulse
module conv_frame_sequencer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int N_FILT = 2,
  parameter int N_TAPS = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       abort,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       tap_pixel,
  output logic [4:0] w_addr,
  output logic       filt_idx,
  output logic       mac_en,
  output logic       acc_clr,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] pos_idx,
  output logic       busy,
  output logic       frame_done
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int N_POS = OUT_W * OUT_H;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_EMIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [ROW_W-1:0] row_cnt_reg, row_cnt_next;
  logic [5:0]       pos_reg, pos_next;
  logic [COL_W-1:0] pos_x_reg, pos_x_next;
  logic [ROW_W-1:0] pos_y_reg, pos_y_next;
  logic             filt_reg, filt_next;
  logic [3:0]       tap_reg, tap_next;
  // Held low through reset so load_ready only rises on the first edge after release.
  logic             ready_en_reg;
  logic [IMG_W-1:0] img_reg [IMG_H];

  logic             row_we;
  logic [ROW_W-1:0] row_sel;
  logic             load_fire;
  logic [1:0]       tap_dx, tap_dy;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] pix_col;

  assign load_ready = ena & ready_en_reg & ((state_reg == ST_IDLE) | (state_reg == ST_LOAD));
  assign load_fire  = load_valid & load_ready;
  assign mac_en     = ena & (state_reg == ST_RUN);
  assign acc_clr    = mac_en & (tap_reg == 4'd0);
  assign res_valid  = (state_reg == ST_EMIT);
  assign frame_done = ena & (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE);
  assign pos_idx    = pos_reg;
  assign filt_idx   = filt_reg;
  assign w_addr     = 5'(filt_reg * N_TAPS) + 5'(tap_reg);

  // Kernel geometry: tap t sits at row t/3, column t%3 of the window.
  always_comb begin
    tap_dy = 2'd0;
    if (tap_reg >= 4'd6)      tap_dy = 2'd2;
    else if (tap_reg >= 4'd3) tap_dy = 2'd1;
    tap_dx = 2'(tap_reg - 4'(3 * tap_dy));
  end

  // Valid convolution: window origin is the output coordinate itself.
  assign pix_row   = pos_y_reg + ROW_W'(tap_dy);
  assign pix_col   = pos_x_reg + COL_W'(tap_dx);
  assign tap_pixel = img_reg[pix_row][pix_col];

  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    pos_next     = pos_reg;
    pos_x_next   = pos_x_reg;
    pos_y_next   = pos_y_reg;
    filt_next    = filt_reg;
    tap_next     = tap_reg;
    row_we       = 1'b0;
    row_sel      = row_cnt_reg;
    if (ena) begin
      if (abort) begin
        state_next   = ST_IDLE;
        row_cnt_next = '0;
        pos_next     = '0;
        pos_x_next   = '0;
        pos_y_next   = '0;
        filt_next    = 1'b0;
        tap_next     = '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (load_fire) begin
              row_we       = 1'b1;
              row_sel      = '0;
              row_cnt_next = ROW_W'(1);
              state_next   = ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (load_fire) begin
              row_we = 1'b1;
              if (row_cnt_reg == ROW_W'(IMG_H - 1)) begin
                row_cnt_next = '0;
                pos_next     = '0;
                pos_x_next   = '0;
                pos_y_next   = '0;
                filt_next    = 1'b0;
                tap_next     = '0;
                state_next   = ST_RUN;
              end else begin
                row_cnt_next = row_cnt_reg + ROW_W'(1);
              end
            end
          end
          ST_RUN: begin
            if (tap_reg == 4'(N_TAPS - 1)) begin
              tap_next = '0;
              if (filt_reg == 1'(N_FILT - 1)) begin
                filt_next  = 1'b0;
                state_next = ST_EMIT;
              end else begin
                filt_next = filt_reg + 1'b1;
              end
            end else begin
              tap_next = tap_reg + 4'd1;
            end
          end
          ST_EMIT: begin
            if (res_ready) begin
              if (pos_reg == 6'(N_POS - 1)) begin
                state_next = ST_DONE;
              end else begin
                pos_next   = pos_reg + 6'd1;
                state_next = ST_RUN;
                // x/y shadow pos so the pixel address needs no divider.
                if (pos_x_reg == COL_W'(OUT_W - 1)) begin
                  pos_x_next = '0;
                  pos_y_next = pos_y_reg + ROW_W'(1);
                end else begin
                  pos_x_next = pos_x_reg + COL_W'(1);
                end
              end
            end
          end
          ST_DONE: begin
            pos_next   = '0;
            pos_x_next = '0;
            pos_y_next = '0;
            state_next = ST_IDLE;
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      row_cnt_reg  <= '0;
      pos_reg      <= '0;
      pos_x_reg    <= '0;
      pos_y_reg    <= '0;
      filt_reg     <= 1'b0;
      tap_reg      <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_cnt_reg  <= row_cnt_next;
      pos_reg      <= pos_next;
      pos_x_reg    <= pos_x_next;
      pos_y_reg    <= pos_y_next;
      filt_reg     <= filt_next;
      tap_reg      <= tap_next;
      ready_en_reg <= 1'b1;
    end
  end

  // One register row per image line; only the addressed row takes the byte.
  generate
    for (genvar gi = 0; gi < IMG_H; gi++) begin : g_row
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          img_reg[gi] <= '0;
        end else if (row_we && (row_sel == ROW_W'(gi))) begin
          img_reg[gi] <= load_data[IMG_W-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: reset, full-frame latency and tap
// sequencing, result back-pressure, abort/reload, enable freeze, async reset.
module tb_conv_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       abort = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  logic       tap_pixel;
  logic [4:0] w_addr;
  logic       filt_idx;
  logic       mac_en;
  logic       acc_clr;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [5:0] pos_idx;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  conv_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .abort(abort),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .tap_pixel(tap_pixel), .w_addr(w_addr), .filt_idx(filt_idx),
    .mac_en(mac_en), .acc_clr(acc_clr), .res_valid(res_valid),
    .res_ready(res_ready), .pos_idx(pos_idx), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    if (rst_n && ena && load_valid && load_ready)
      $display("[%0t] load row data=%02h", $time, load_data);
    if (rst_n && ena && res_valid && res_ready)
      $display("[%0t] result accepted pos=%0d", $time, pos_idx);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Loads rows first..last of a packed frame (row r at bits r*8+:8).
  task automatic load_rows(input logic [63:0] frame, input int first, input int last,
                           output int t0);
    t0 = 0;
    for (int r = first; r <= last; r++) begin
      int n = 0;
      load_data  = frame[r*8 +: 8];
      load_valid = 1'b1;
      #0;
      while (!load_ready && n < 50) begin
        tick();
        n++;
      end
      checks++;
      if (n >= 50) begin
        errors++;
        $display("FAIL load_wait: load_ready got 0 required 1 at row %0d", r);
      end
      tick();
      if (r == 0) t0 = cyc_cnt;
    end
    load_valid = 1'b0;
  endtask

  task automatic wait_pos(input logic [5:0] p);
    int n = 0;
    while (pos_idx != p && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL wait_pos: pos_idx got %0d required %0d", pos_idx, p);
    end
  endtask

  task automatic wait_res_valid;
    int n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL wait_res_valid: res_valid got 0 required 1");
    end
  endtask

  task automatic wait_frame_done(output int waited);
    int n = 0;
    while (!frame_done && n < 2000) begin
      tick();
      n++;
    end
    waited = n;
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL wait_frame_done: frame_done got 0 required 1");
    end
  endtask

  function automatic logic [63:0] diag_frame();
    logic [63:0] f;
    for (int r = 0; r < 8; r++) f[r*8 +: 8] = 8'(1 << r);
    return f;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready: got %b required 0", load_ready); end
    checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL rst_mac_en: got %b required 0", mac_en); end
    checks++; if (acc_clr !== 1'b0) begin errors++; $display("FAIL rst_acc_clr: got %b required 0", acc_clr); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b required 0", res_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    checks++; if (pos_idx !== 6'd0) begin errors++; $display("FAIL rst_pos_idx: got %0d required 0", pos_idx); end
    checks++; if (w_addr !== 5'd0) begin errors++; $display("FAIL rst_w_addr: got %0d required 0", w_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_release_load_ready: got %b required 1", load_ready); end
  endtask

  // Diagonal image, first-position tap sequence and full-frame latency.
  task automatic test_frame_latency;
    int t0, waited;
    logic exp_clr;
    res_ready = 1'b1;
    load_rows(diag_frame(), 0, 7, t0);
    for (int i = 0; i < 18; i++) begin
      exp_clr = (i == 0 || i == 9);
      checks++; if (w_addr !== 5'(i)) begin errors++; $display("FAIL seq_w_addr: got %0d required %0d", w_addr, i); end
      checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL seq_mac_en: got %b required 1 at tap %0d", mac_en, i); end
      checks++; if (acc_clr !== exp_clr) begin errors++; $display("FAIL seq_acc_clr: got %b required %b at w_addr %0d", acc_clr, exp_clr, i); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL seq_res_valid: got %b required 0 at w_addr %0d", res_valid, i); end
      if (i == 0) begin
        checks++; if (tap_pixel !== 1'b1) begin errors++; $display("FAIL pix_tap0: got %b required 1", tap_pixel); end
      end
      if (i == 1) begin
        checks++; if (tap_pixel !== 1'b0) begin errors++; $display("FAIL pix_tap1: got %b required 0", tap_pixel); end
      end
      if (i == 4) begin
        checks++; if (tap_pixel !== 1'b1) begin errors++; $display("FAIL pix_tap4: got %b required 1", tap_pixel); end
      end
      tick();
    end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL emit_res_valid: got %b required 1", res_valid); end
    checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL emit_mac_en: got %b required 0", mac_en); end
    wait_frame_done(waited);
    // Both the acceptance cycle of row 0 and the pulse cycle are counted.
    checks++; if ((cyc_cnt - t0) + 2 != 693) begin errors++; $display("FAIL latency: got %0d cycles required 693", (cyc_cnt - t0) + 2); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b required 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_idle_busy: got %b required 0", busy); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL done_idle_load_ready: got %b required 1", load_ready); end
  endtask

  task automatic test_backpressure;
    int t0;
    res_ready = 1'b1;
    load_rows(diag_frame(), 0, 7, t0);
    wait_pos(6'd3);
    res_ready = 1'b0;
    wait_res_valid();
    for (int i = 0; i < 5; i++) begin
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_res_valid: got %b required 1", res_valid); end
      checks++; if (pos_idx !== 6'd3) begin errors++; $display("FAIL stall_pos_idx: got %0d required 3", pos_idx); end
      checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL stall_mac_en: got %b required 0", mac_en); end
      tick();
    end
    res_ready = 1'b1;
    tick();
    checks++; if (pos_idx !== 6'd4) begin errors++; $display("FAIL stall_release_pos: got %0d required 4", pos_idx); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_release_res_valid: got %b required 0", res_valid); end
    checks++; if (acc_clr !== 1'b1) begin errors++; $display("FAIL stall_release_acc_clr: got %b required 1", acc_clr); end
  endtask

  // Continues the frame from test_backpressure.
  task automatic test_abort;
    int t0, waited;
    logic [63:0] ones = {64{1'b1}};
    wait_pos(6'd20);
    res_ready = 1'b0;
    wait_res_valid();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_res_valid: got %b required 0", res_valid); end
    checks++; if (pos_idx !== 6'd0) begin errors++; $display("FAIL abort_pos_idx: got %0d required 0", pos_idx); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL abort_load_ready: got %b required 1", load_ready); end
    load_rows(ones, 0, 7, t0);
    checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL reload_mac_en: got %b required 1", mac_en); end
    checks++; if (pos_idx !== 6'd0) begin errors++; $display("FAIL reload_pos_idx: got %0d required 0", pos_idx); end
    checks++; if (w_addr !== 5'd0) begin errors++; $display("FAIL reload_w_addr: got %0d required 0", w_addr); end
    load_valid = 1'b1;
    load_data  = 8'h00;
    tick();
    checks++; if (tap_pixel !== 1'b1) begin errors++; $display("FAIL reload_pix_tap1: got %b required 1", tap_pixel); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL run_load_ready: got %b required 0", load_ready); end
    load_valid = 1'b0;
    res_ready  = 1'b1;
    wait_frame_done(waited);
    tick();
  endtask

  task automatic test_enable_freeze;
    int t0;
    logic [63:0] f;
    f = {8'h11, 8'h22, 8'h44, 8'h88, 8'h00, 8'h02, 8'h00, 8'h01};
    res_ready = 1'b1;
    load_rows(f, 0, 3, t0);
    ena = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #0;
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ena_load_ready: got %b required 0", load_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ena_load_busy: got %b required 1", busy); end
      tick();
    end
    ena = 1'b1;
    load_rows(f, 4, 7, t0);
    checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL ena_resume_run: got %b required 1", mac_en); end
    checks++; if (tap_pixel !== 1'b1) begin errors++; $display("FAIL ena_pix_tap0: got %b required 1", tap_pixel); end
    for (int i = 0; i < 7; i++) tick();
    checks++; if (w_addr !== 5'd7) begin errors++; $display("FAIL ena_reach_w7: got %0d required 7", w_addr); end
    // tap 7 reads img[2][1]; row 2 is 8'h02.
    checks++; if (tap_pixel !== 1'b1) begin errors++; $display("FAIL ena_pix_tap7: got %b required 1", tap_pixel); end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #0;
      checks++; if (w_addr !== 5'd7) begin errors++; $display("FAIL ena_run_w_addr: got %0d required 7", w_addr); end
      checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL ena_run_mac_en: got %b required 0", mac_en); end
      tick();
    end
    ena = 1'b1;
    #0;
    checks++; if (mac_en !== 1'b1) begin errors++; $display("FAIL ena_run_resume_mac: got %b required 1", mac_en); end
    tick();
    checks++; if (w_addr !== 5'd8) begin errors++; $display("FAIL ena_run_resume_w: got %0d required 8", w_addr); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_abort_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int t0;
    res_ready = 1'b1;
    load_rows(diag_frame(), 0, 7, t0);
    wait_pos(6'd10);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b required 0", busy); end
    checks++; if (pos_idx !== 6'd0) begin errors++; $display("FAIL arst_pos_idx: got %0d required 0", pos_idx); end
    checks++; if (mac_en !== 1'b0) begin errors++; $display("FAIL arst_mac_en: got %b required 0", mac_en); end
    checks++; if (w_addr !== 5'd0) begin errors++; $display("FAIL arst_w_addr: got %0d required 0", w_addr); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL arst_load_ready: got %b required 0", load_ready); end
    // Counters at 0 address img[0][0], which the diagonal set; reset clears it.
    checks++; if (tap_pixel !== 1'b0) begin errors++; $display("FAIL arst_buffer_clear: got %b required 0", tap_pixel); end
    tick();
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL arst_hold_load_ready: got %b required 0", load_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL arst_release_early: got %b required 0", load_ready); end
    tick();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL arst_release_load_ready: got %b required 1", load_ready); end
  endtask

  initial begin
    test_reset();
    test_frame_latency();
    test_backpressure();
    test_abort();
    test_enable_freeze();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
